psum_acc_ctrl: RTL and testbench

//  Sequences one signed saturating accumulator over a run of partial sums.

---
 rtl/psum_acc_if.sv | 28 ++
 rtl/psum_acc_ctrl.sv | 123 ++++++++++++
 tb/tb_psum_acc_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/psum_acc_if.sv
// Stream bundle between the adder tree, the partial-sum accumulator and the
// writeback stage: run control, input term stream, result stream and status.
interface psum_acc_if #(
    parameter int IN_W  = 17,
    parameter int ACC_W = 18,
    parameter int LEN_W = 8
);
    logic                    start;
    logic [LEN_W-1:0]        len;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    busy;
    logic                    sat_flag;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy, sat_flag
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy, sat_flag
    );
endinterface

// File: rtl/psum_acc_ctrl.sv
// Sequences one signed saturating accumulator over a run of LEN partial sums
// and hands the clamped total to the writeback stage on a valid/ready port.
module psum_acc_ctrl #(
    parameter int IN_W  = 17,
    parameter int ACC_W = 18,
    parameter int LEN_W = 8
) (
    input logic       clk,
    input logic       reset,
    psum_acc_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [ACC_W-1:0] r_acc;
    logic [LEN_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        r_len;
    logic                    r_sat;

    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic                    w_clamp;
    logic                    w_xfer;
    logic                    w_last;

    assign w_xfer = bus.in_valid && (r_state == S_ACC);
    assign w_last = (r_cnt == r_len - LEN_W'(1));

    // One guard bit above the accumulator: the top two bits of the sum tell
    // positive overflow (01) from negative overflow (10).
    // NOTE: combinational blocks use blocking '=' with every output defaulted
    // first, so no path through the block leaves a value held (no latch).
    always_comb begin
        w_sum     = {r_acc[ACC_W-1], r_acc}
                  + {{(ACC_W+1-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
        w_acc_nxt = w_sum[ACC_W-1:0];
        w_clamp   = 1'b0;
        case (w_sum[ACC_W:ACC_W-1])
            2'b01: begin
                w_acc_nxt = ACC_MAX;
                w_clamp   = 1'b1;
            end
            2'b10: begin
                w_acc_nxt = ACC_MIN;
                w_clamp   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.len != '0) ? S_ACC : S_OUT;
                end
            end
            S_ACC: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && w_last) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: reset is synchronous and uses non-blocking '<=' like all state;
    // it wins over any run in progress and the partial sum is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_len <= bus.len;
                        r_sat <= 1'b0;
                    end
                end
                S_ACC: begin
                    if (w_xfer) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_clamp) begin
                            r_sat <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The result comes straight from the accumulator, which is frozen in OUT.
    assign bus.out_data = r_acc;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.sat_flag = r_sat;
endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Directed bench for psum_acc_ctrl: stimulus pushes expected results into a
// scoreboard queue, an independent monitor pops them as results are taken.
module tb_psum_acc_ctrl;
    localparam int IN_W  = 17;
    localparam int ACC_W = 18;
    localparam int LEN_W = 8;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic             sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    psum_acc_if #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

    psum_acc_ctrl #(.IN_W(IN_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic chk_data(input string name, input logic [ACC_W-1:0] act,
                            input logic [ACC_W-1:0] exp);
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic push_exp(input int value, input logic sat);
        exp_t        e;
        logic [31:0] v;
        v      = value;
        e.data = v[ACC_W-1:0];
        e.sat  = sat;
        sb.push_back(e);
    endtask

    // All drivers below are called at posedge+1 and return at posedge+1.
    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input int l);
        bus.start = 1'b1;
        bus.len   = LEN_W'(l);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input int term, input bit last, input string tag);
        int t;
        bus.in_valid = 1'b1;
        bus.in_data  = IN_W'(term);
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 20) begin
            t++;
            @(negedge clk);
        end
        chk_bit({tag, "_in_ready"}, bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (last) chk_bit({tag, "_latency"}, bus.out_valid, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (bus.busy && t < 50) begin
            t++;
            gap(1);
        end
        chk_bit({tag, "_idle"}, bus.busy, 1'b0);
    endtask

    // Monitor: a result is consumed on the edge after a valid&ready sample.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk_bit("out_unexpected", bus.out_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk_data("out_data", bus.out_data, e.data);
                    chk_bit("out_sat_flag", bus.sat_flag, e.sat);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin : stimulus
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        gap(2);
        chk_bit("rst_in_ready", bus.in_ready, 1'b0);
        chk_bit("rst_out_valid", bus.out_valid, 1'b0);
        chk_bit("rst_busy", bus.busy, 1'b0);
        chk_bit("rst_sat_flag", bus.sat_flag, 1'b0);
        reset = 1'b0;
        gap(1);

        // T1: reset after 2 of 4 terms discards the run
        start_run(4);
        send(100, 1'b0, "t1a");
        send(200, 1'b0, "t1b");
        reset = 1'b1;
        gap(1);
        reset = 1'b0;
        chk_bit("t1_in_ready", bus.in_ready, 1'b0);
        chk_bit("t1_out_valid", bus.out_valid, 1'b0);
        chk_bit("t1_busy", bus.busy, 1'b0);
        chk_bit("t1_sat_flag", bus.sat_flag, 1'b0);
        gap(2);
        chk_bit("t1_no_output", bus.out_valid, 1'b0);

        // T2: 5 - 2 + 10 = 13 with in_valid gaps
        push_exp(13, 1'b0);
        start_run(3);
        send(5, 1'b0, "t2a");
        gap(2);
        send(-2, 1'b0, "t2b");
        gap(3);
        send(10, 1'b1, "t2c");
        wait_idle("t2");
        gap(1);

        // T3a: 65535 + 65535 = 131070 lands one below +max, no clamp
        push_exp(131070, 1'b0);
        start_run(2);
        send(65535, 1'b0, "t3a0");
        send(65535, 1'b1, "t3a1");
        wait_idle("t3a");

        // T3b: a third 65535 pushes past +max and clamps to 0x1FFFF
        push_exp(131071, 1'b1);
        start_run(3);
        send(65535, 1'b0, "t3b0");
        send(65535, 1'b0, "t3b1");
        send(65535, 1'b1, "t3b2");
        wait_idle("t3b");

        // T4: -65536 x3 clamps at -131072, then +100 pulls back to -130972
        push_exp(-130972, 1'b1);
        start_run(4);
        send(-65536, 1'b0, "t4a");
        send(-65536, 1'b0, "t4b");
        send(-65536, 1'b0, "t4c");
        send(100, 1'b1, "t4d");
        wait_idle("t4");
        chk_bit("t4_sat_hold_idle", bus.sat_flag, 1'b1);

        // T5: empty run, result held while the consumer stalls
        bus.out_ready = 1'b0;
        push_exp(0, 1'b0);
        start_run(0);
        chk_bit("t5_out_valid_next", bus.out_valid, 1'b1);
        chk_bit("t5_sat_cleared", bus.sat_flag, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_bit("t5_hold_valid", bus.out_valid, 1'b1);
            chk_data("t5_hold_data", bus.out_data, '0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_idle("t5");

        // T6: start ignored in ACC and in OUT, honoured in a later IDLE
        push_exp(131071, 1'b1);
        start_run(3);
        send(65535, 1'b0, "t6a");
        bus.start = 1'b1;
        bus.len   = LEN_W'(0);
        send(65535, 1'b0, "t6b");
        bus.start = 1'b0;
        send(65535, 1'b1, "t6c");
        bus.start = 1'b1;
        bus.len   = LEN_W'(1);
        gap(1);
        bus.start = 1'b0;
        chk_bit("t6_out_start_ignored", bus.busy, 1'b0);
        chk_bit("t6_no_extra_output", bus.out_valid, 1'b0);
        chk_bit("t6_sat_hold", bus.sat_flag, 1'b1);
        push_exp(3, 1'b0);
        start_run(1);
        chk_bit("t6_sat_cleared", bus.sat_flag, 1'b0);
        send(3, 1'b1, "t6d");
        wait_idle("t6");

        gap(2);
        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
